pc_163: RTL and testbench
=========================

# pc_163

4-bit loadable, clearable binary up-counter modelled on the 74x163, with an enable and a terminal-count output for cascading. In the BURP processor it is the controller's step counter. The controller decodes its `Q` outputs into time steps T0..T7 and drives `clear_n` from its END signal to restart the instruction sequence. The counter is also usable as a generic program/sequence counter.

## Interface
- `WIDTH`, default 4: counter width in bits. The processor uses the default.
- `clock`: input, 1 bit. Single clock; all state changes on its rising edge, except clear.
- `clear_n`: input, 1 bit. Asynchronous, active-low reset/clear. Low forces `Q` to 0 immediately.
- `D`: input, `WIDTH` bits. Parallel load data.
- `load_n`: input, 1 bit. Active-low synchronous parallel load.
- `Q`: output, `WIDTH` bits. Registered count value.
- `enable`: input, 1 bit. Active-high count enable.
- `TC`: output, 1 bit. Terminal count. Combinational: `enable` AND (`Q` == all ones).
- Port order for positional instantiation: `clear_n`, `D`, `load_n`, `Q`, `clock`, `enable`, `TC`.

## Operation
- Clear:
  - While `clear_n` = 0, `Q` = 0 regardless of `clock`, `load_n`, `enable` or `D`.
  - Clear has the highest priority.
- Load:
  - At a rising edge of `clock` with `clear_n` = 1 and `load_n` = 0, `Q` takes `D`.
  - Load ignores `enable`, as on the 74x163.
- Count:
  - At a rising edge with `clear_n` = 1, `load_n` = 1 and `enable` = 1, `Q` takes `Q` + 1, modulo 2^`WIDTH`.
  - 4'hF wraps to 4'h0 with no error flag.
- Hold: at a rising edge with `clear_n` = 1, `load_n` = 1 and `enable` = 0, `Q` is unchanged.
- Priority: clear > load > count > hold.
- Terminal count:
  - `TC` = `enable` & (&`Q`). It is not registered and has no clock dependency.
  - `TC` follows `enable` and `Q` combinationally, so it can drive the next stage's `enable`.
- `D` is sampled only at the load edge. Changes to `D` at any other time have no effect.

## Timing
- Reset values: `Q` = 0 and `TC` = 0, provided `enable` is not driven high while `Q` = 0 (all-zero `Q` never gives `TC` = 1 for `WIDTH` ≥ 1).
- Clear assertion: `Q` goes to 0 in the same delta/cycle, with no clock edge needed.
- Clear release:
  - The first effective edge is the first rising edge after `clear_n` is sampled high.
  - A release coincident with a clock edge gives no count on that edge.
- Load latency: 1 cycle. `Q` = `D` after the edge at which `load_n` = 0 was sampled.
- Count latency: 1 cycle per increment.
- `TC` latency: 0 cycles after `Q` or `enable` changes.
- Simultaneous `load_n` = 0 and `enable` = 1: load wins, and `Q` = `D` with no increment.
- Wrap-around: at `Q` = max with `enable` = 1, `TC` = 1 during that cycle. At the next edge `Q` = 0 and `TC` falls to 0.
- Clear held for multiple cycles: `Q` stays 0 and no counting occurs.

## Structure
- Single flat module.
- No shared-package content needed. `WIDTH` is a local parameter default; the processor opcode and ALU constants stay in the controller's package, not here.
- No sub-modules: one `always` block with async clear for the register, and one continuous assign for `TC`.
- Implement as a behavioural register, not gate-level 74x163 emulation. The default build must be exactly the 4-bit behaviour described above.

## Test plan
- Reset:
  - Drive `clear_n` = 0 mid-count at `Q` = 5, between clock edges. Required: `Q` = 0 immediately, before the next edge.
  - Then hold 3 edges with `enable` = 1. Required: `Q` stays 0.
- Count and wrap:
  - Release clear, `enable` = 1, 16 edges. Required: `Q` steps 0,1,…,F,0.
  - Required: `TC` = 1 only while `Q` = F.
- Load priority:
  - `Q` = 3, `D` = 4'hA, `load_n` = 0, `enable` = 1, one edge. Required: `Q` = A, not 4 or B.
  - Then `load_n` = 1, one edge. Required: `Q` = B.
- Hold:
  - `Q` = 7, `enable` = 0, `load_n` = 1, 4 edges. Required: `Q` stays 7, `TC` = 0.
  - Load F with `enable` = 0. Required: `TC` = 0.
  - Raise `enable`. Required: `TC` = 1 with no clock edge.
- Clear vs load:
  - `clear_n` = 0 with `load_n` = 0, `D` = 4'hC across an edge. Required: `Q` = 0.
- Cascade:
  - Two instances; the low stage's `TC` drives the high stage's `enable`; low `enable` = 1.
  - Required: high stage increments only on edges where low `Q` = F. After 32 edges the high stage = 2.

Source files
------------

// File: rtl/pc_163_pkg.sv
// Shared constants for the 74x163-style step counter.
// Holds only the default width so the counter and its users agree on it.
package pc_163_pkg;

  localparam int PC_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/pc_163.sv
// Loadable, clearable up-counter (74x163 behaviour); Q updates 1 cycle after load/count, clear is immediate.
// TC is combinational (enable & Q all ones) so it can drive a cascaded stage's enable; no backpressure.
module pc_163
  import pc_163_pkg::*;
#(
  parameter int WIDTH = PC_DEFAULT_WIDTH
) (
  input  logic             clear_n,
  input  logic [WIDTH-1:0] D,
  input  logic             load_n,
  output logic [WIDTH-1:0] Q,
  input  logic             clock,
  input  logic             enable,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;

  // Priority clear > load > count > hold; load deliberately ignores enable.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_q <= '0;
    end else if (!load_n) begin
      r_q <= D;
    end else if (enable) begin
      r_q <= r_q + ONE;
    end
  end

  assign Q  = r_q;
  assign TC = enable & (&r_q);

endmodule

// File: tb/tb_pc_163.sv
module tb_pc_163;

  logic       clock;
  logic       clear_n;
  logic [3:0] d;
  logic       load_n;
  logic       enable;
  logic [3:0] q;
  logic       tc;

  logic       c_clr_n;
  logic [3:0] lo_q;
  logic       lo_tc;
  logic [3:0] hi_q;
  logic       hi_tc;
  logic [3:0] c_d;
  logic       c_load_n;
  logic       c_lo_en;

  pc_163 dut (
    .clear_n(clear_n), .D(d), .load_n(load_n), .Q(q),
    .clock(clock), .enable(enable), .TC(tc)
  );

  pc_163 u_lo (
    .clear_n(c_clr_n), .D(c_d), .load_n(c_load_n), .Q(lo_q),
    .clock(clock), .enable(c_lo_en), .TC(lo_tc)
  );

  pc_163 u_hi (
    .clear_n(c_clr_n), .D(c_d), .load_n(c_load_n), .Q(hi_q),
    .clock(clock), .enable(lo_tc), .TC(hi_tc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Scoreboard: sel 0 = main counter, 1 = cascade low stage, 2 = cascade high stage
  typedef struct {
    string      name;
    int         sel;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  bit   sample_req = 1'b0;
  int   errors = 0;
  int   checks = 0;

  initial begin
    exp_t       e;
    logic [3:0] aq;
    logic       atc;
    forever begin
      @(sample_req);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          1:       begin aq = lo_q; atc = lo_tc; end
          2:       begin aq = hi_q; atc = hi_tc; end
          default: begin aq = q;    atc = tc;    end
        endcase
        checks++;
        if (aq !== e.q || atc !== e.tc) begin
          errors++;
          $display("FAIL %s: got Q=%h TC=%b, required Q=%h TC=%b", e.name, aq, atc, e.q, e.tc);
        end
      end
    end
  end

  task automatic chk(input string nm, input int sel, input logic [3:0] eq, input logic etc);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.q    = eq;
    e.tc   = etc;
    sb.push_back(e);
    sample_req = ~sample_req;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, required completion before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp;
    clear_n  = 1'b0;
    d        = 4'h0;
    load_n   = 1'b1;
    enable   = 1'b0;
    c_clr_n  = 1'b0;
    c_d      = 4'h0;
    c_load_n = 1'b1;
    c_lo_en  = 1'b1;
    #2;
    chk("reset", 0, 4'h0, 1'b0);

    // Count to 5, then clear between edges
    @(negedge clock);
    clear_n = 1'b1;
    enable  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      edge_step();
      exp = 4'(i);
      chk("count_to_5", 0, exp, 1'b0);
    end
    #1;
    clear_n = 1'b0;
    #1;
    chk("async_clear", 0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("clear_held", 0, 4'h0, 1'b0);
    end

    // Release and count through wrap
    clear_n = 1'b1;
    chk("release", 0, 4'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      edge_step();
      exp = 4'(k);
      chk("count_wrap", 0, exp, exp == 4'hF);
    end

    // Load beats count
    load_n = 1'b0;
    d      = 4'h3;
    edge_step();
    chk("load3", 0, 4'h3, 1'b0);
    d = 4'hA;
    edge_step();
    chk("load_priority", 0, 4'hA, 1'b0);
    load_n = 1'b1;
    edge_step();
    chk("count_after_load", 0, 4'hB, 1'b0);

    // Hold, D changes without load, TC gating by enable
    enable = 1'b0;
    load_n = 1'b0;
    d      = 4'h7;
    edge_step();
    chk("load7", 0, 4'h7, 1'b0);
    load_n = 1'b1;
    d      = 4'h2;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      chk("hold", 0, 4'h7, 1'b0);
    end
    load_n = 1'b0;
    d      = 4'hF;
    edge_step();
    chk("loadF_en0", 0, 4'hF, 1'b0);
    load_n = 1'b1;
    enable = 1'b1;
    #1;
    chk("tc_comb_rise", 0, 4'hF, 1'b1);
    enable = 1'b0;
    #1;
    chk("tc_comb_fall", 0, 4'hF, 1'b0);

    // Clear beats load
    d       = 4'hC;
    load_n  = 1'b0;
    enable  = 1'b1;
    clear_n = 1'b0;
    #1;
    chk("clear_vs_load_now", 0, 4'h0, 1'b0);
    edge_step();
    chk("clear_vs_load_edge", 0, 4'h0, 1'b0);
    clear_n = 1'b1;
    load_n  = 1'b1;
    edge_step();
    chk("first_edge_after_release", 0, 4'h1, 1'b0);

    // Two-stage cascade
    c_clr_n = 1'b1;
    chk("cascade_lo_start", 1, 4'h0, 1'b0);
    chk("cascade_hi_start", 2, 4'h0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      edge_step();
      exp = 4'(k % 16);
      chk("cascade_lo", 1, exp, exp == 4'hF);
      exp = 4'(k / 16);
      chk("cascade_hi", 2, exp, 1'b0);
    end

    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
